// File: rtl/instruction_fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional fetch counter is enabled by defining FETCH_COUNT_EN.
package instruction_fetch_stage_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int unsigned DEFAULT_PC_INCR = 4;
    localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instruction;
        logic [XLEN-1:0] pcplus4;
        logic            valid;
    } if_id_t;

    localparam if_id_t IF_ID_EMPTY = '{instruction: NOP_WORD, pcplus4: '0, valid: 1'b0};

    // Force a byte address onto a word boundary.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_stage_if_id_register.sv
// IF/ID pipeline register with hold (stall) and clear (flush) controls.
// Priority: reset > clear > hold > load.
module instruction_fetch_stage_if_id_register
    import instruction_fetch_stage_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   hold,
    input  logic   clear,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= IF_ID_EMPTY;
        end else if (clear) begin
            q <= IF_ID_EMPTY;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: owns the PC, addresses the instruction memory, fills IF/ID.
// Define FETCH_COUNT_EN to add the FetchCount output.
module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned     PC_INCR  = DEFAULT_PC_INCR
) (
    input  logic            Clk,
    input  logic            Reset,
    output logic [XLEN-1:0] ImemAddress,
    input  logic [XLEN-1:0] ImemInstruction,
    input  logic            Stall,
    input  logic            Redirect,
    input  logic [XLEN-1:0] RedirectTarget,
    input  logic            Halt,
    output logic [XLEN-1:0] IfId_Instruction,
    output logic [XLEN-1:0] IfId_PCPlus4,
    output logic            IfId_Valid,
`ifdef FETCH_COUNT_EN
    output logic [XLEN-1:0] FetchCount,
`endif
    output logic            Halted
);

    fetch_state_e    state;
    fetch_state_e    state_next;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] pc_plus;
    logic            ifid_hold;
    logic            ifid_clear;
    logic            advance;
    logic            halted_q;
    if_id_t          ifid_d;
    if_id_t          ifid_q;

    assign pc_plus     = pc + XLEN'(PC_INCR);
    assign ImemAddress = pc;

    // State register
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state: HALTED is sticky until reset
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (Halt) state_next = HALTED;
            HALTED:  state_next = HALTED;
            default: state_next = RUN;
        endcase
    end

    // Per-edge control: Halt > Redirect > Stall > sequential fetch
    always_comb begin
        pc_next    = pc;
        ifid_hold  = 1'b0;
        ifid_clear = 1'b0;
        advance    = 1'b0;
        case (state)
            RUN: begin
                if (Halt) begin
                    ifid_clear = 1'b1;
                end else if (Redirect) begin
                    pc_next    = align_word(RedirectTarget);
                    ifid_clear = 1'b1;
                end else if (Stall) begin
                    ifid_hold = 1'b1;
                end else begin
                    pc_next = pc_plus;
                    advance = 1'b1;
                end
            end
            default: begin
                ifid_clear = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            pc       <= align_word(RESET_PC);
            halted_q <= 1'b0;
        end else begin
            pc       <= pc_next;
            halted_q <= (state_next == HALTED);
        end
    end

    assign ifid_d = '{instruction: ImemInstruction, pcplus4: pc_plus, valid: 1'b1};

    instruction_fetch_stage_if_id_register u_if_id_register (
        .clk   (Clk),
        .rst_n (Reset),
        .hold  (ifid_hold),
        .clear (ifid_clear),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign IfId_Instruction = ifid_q.instruction;
    assign IfId_PCPlus4     = ifid_q.pcplus4;
    assign IfId_Valid       = ifid_q.valid;
    assign Halted           = halted_q;

`ifdef FETCH_COUNT_EN
    // Counts edges that load a valid IF/ID entry
    logic [XLEN-1:0] fetch_count_q;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            fetch_count_q <= '0;
        end else if (advance) begin
            fetch_count_q <= fetch_count_q + XLEN'(1);
        end
    end

    assign FetchCount = fetch_count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed, table-driven bench for instruction_fetch_stage.
// Define FETCH_COUNT_EN to also check FetchCount.
module tb_instruction_fetch_stage;

    logic        Clk;
    logic        Reset;
    logic [31:0] ImemAddress;
    logic [31:0] ImemInstruction;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectTarget;
    logic        Halt;
    logic [31:0] IfId_Instruction;
    logic [31:0] IfId_PCPlus4;
    logic        IfId_Valid;
    logic        Halted;
`ifdef FETCH_COUNT_EN
    logic [31:0] FetchCount;
`endif

    int checks = 0;
    int errors = 0;

    instruction_fetch_stage dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .ImemAddress      (ImemAddress),
        .ImemInstruction  (ImemInstruction),
        .Stall            (Stall),
        .Redirect         (Redirect),
        .RedirectTarget   (RedirectTarget),
        .Halt             (Halt),
        .IfId_Instruction (IfId_Instruction),
        .IfId_PCPlus4     (IfId_PCPlus4),
        .IfId_Valid       (IfId_Valid),
`ifdef FETCH_COUNT_EN
        .FetchCount       (FetchCount),
`endif
        .Halted           (Halted)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Memory model: word i holds i*3
    assign ImemInstruction = 32'(ImemAddress[11:2]) * 32'd3;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redir;
        logic [31:0] tgt;
        logic        halt;
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] p4;
        logic        v;
        logic        h;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[26];

    function automatic vec_t mk(input logic rst, input logic stall, input logic redir,
                                input logic [31:0] tgt, input logic halt,
                                input logic [31:0] pc, input logic [31:0] ins,
                                input logic [31:0] p4, input logic v, input logic h,
                                input logic [31:0] cnt);
        vec_t r;
        r.rst = rst; r.stall = stall; r.redir = redir; r.tgt = tgt; r.halt = halt;
        r.pc = pc; r.ins = ins; r.p4 = p4; r.v = v; r.h = h; r.cnt = cnt;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                             input logic [31:0] p4, input logic v, input logic h,
                             input logic [31:0] cnt);
        check({tag, " pc"}, ImemAddress, pc);
        check({tag, " instr"}, IfId_Instruction, ins);
        check({tag, " pcplus4"}, IfId_PCPlus4, p4);
        check({tag, " valid"}, 32'(IfId_Valid), 32'(v));
        check({tag, " halted"}, 32'(Halted), 32'(h));
`ifdef FETCH_COUNT_EN
        check({tag, " count"}, FetchCount, cnt);
`else
        if (cnt == 32'hFFFF_FFFF) $display("unexpected count tag %s", tag);
`endif
    endtask

    task automatic apply(input logic rst, input logic stall, input logic redir,
                         input logic [31:0] tgt, input logic halt);
        Reset = ~rst; Stall = stall; Redirect = redir; RedirectTarget = tgt; Halt = halt;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b0; Stall = 1'b0; Redirect = 1'b0; RedirectTarget = '0; Halt = 1'b0;

        //             rst stall red tgt            halt pc            ins    p4            v  h  cnt
        vecs[0]  = mk(1, 0, 0, 32'h0,          0, 32'h0,          0,     32'h0,  0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 32'h0,          0, 32'h4,          0,     32'h4,  1, 0, 1);
        vecs[2]  = mk(0, 0, 0, 32'h0,          0, 32'h8,          3,     32'h8,  1, 0, 2);
        vecs[3]  = mk(0, 0, 0, 32'h0,          0, 32'hC,          6,     32'hC,  1, 0, 3);
        vecs[4]  = mk(0, 0, 0, 32'h0,          0, 32'h10,         9,     32'h10, 1, 0, 4);
        vecs[5]  = mk(0, 1, 0, 32'h0,          0, 32'h10,         9,     32'h10, 1, 0, 4);
        vecs[6]  = mk(0, 1, 0, 32'h0,          0, 32'h10,         9,     32'h10, 1, 0, 4);
        vecs[7]  = mk(0, 0, 0, 32'h0,          0, 32'h14,         12,    32'h14, 1, 0, 5);
        vecs[8]  = mk(0, 1, 1, 32'h43,         0, 32'h40,         0,     32'h0,  0, 0, 5);
        vecs[9]  = mk(0, 0, 0, 32'h0,          0, 32'h44,         48,    32'h44, 1, 0, 6);
        vecs[10] = mk(0, 0, 1, 32'h20,         0, 32'h20,         0,     32'h0,  0, 0, 6);
        vecs[11] = mk(0, 0, 1, 32'h80,         1, 32'h20,         0,     32'h0,  0, 1, 6);
        vecs[12] = mk(0, 0, 1, 32'h80,         0, 32'h20,         0,     32'h0,  0, 1, 6);
        vecs[13] = mk(0, 1, 0, 32'h0,          0, 32'h20,         0,     32'h0,  0, 1, 6);
        vecs[14] = mk(0, 0, 0, 32'h0,          1, 32'h20,         0,     32'h0,  0, 1, 6);
        vecs[15] = mk(0, 0, 0, 32'h0,          0, 32'h20,         0,     32'h0,  0, 1, 6);
        vecs[16] = mk(1, 0, 0, 32'h0,          0, 32'h0,          0,     32'h0,  0, 0, 0);
        vecs[17] = mk(0, 0, 1, 32'hFFFF_FFFC,  0, 32'hFFFF_FFFC,  0,     32'h0,  0, 0, 0);
        vecs[18] = mk(0, 0, 0, 32'h0,          0, 32'h0,          3069,  32'h0,  1, 0, 1);
        vecs[19] = mk(0, 0, 0, 32'h0,          0, 32'h4,          0,     32'h4,  1, 0, 2);
        vecs[20] = mk(1, 1, 1, 32'h100,        0, 32'h0,          0,     32'h0,  0, 0, 0);
        vecs[21] = mk(0, 0, 0, 32'h0,          0, 32'h4,          0,     32'h4,  1, 0, 1);
        vecs[22] = mk(0, 0, 0, 32'h0,          0, 32'h8,          3,     32'h8,  1, 0, 2);
        vecs[23] = mk(0, 0, 0, 32'h0,          0, 32'hC,          6,     32'hC,  1, 0, 3);
        vecs[24] = mk(0, 1, 0, 32'h0,          1, 32'hC,          0,     32'h0,  0, 1, 3);
        vecs[25] = mk(1, 0, 0, 32'h0,          1, 32'h0,          0,     32'h0,  0, 0, 0);

        for (int i = 0; i < 26; i++) begin
            apply(vecs[i].rst, vecs[i].stall, vecs[i].redir, vecs[i].tgt, vecs[i].halt);
            check_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].ins, vecs[i].p4,
                      vecs[i].v, vecs[i].h, vecs[i].cnt);
        end

        // Long stall after one fetch: everything holds, then resumes in order
        apply(0, 0, 0, 32'h0, 0);
        check_all("seq fetch", 32'h4, 32'h0, 32'h4, 1'b1, 1'b0, 32'd1);
        for (int k = 0; k < 4; k++) begin
            apply(0, 1, 0, 32'h0, 0);
            check_all($sformatf("seq stall%0d", k), 32'h4, 32'h0, 32'h4, 1'b1, 1'b0, 32'd1);
        end
        apply(0, 0, 0, 32'h0, 0);
        check_all("seq resume", 32'h8, 32'd3, 32'h8, 1'b1, 1'b0, 32'd2);

        // Misaligned redirect with low bits 2'b11 into a high address, then a fetch there
        apply(0, 0, 1, 32'h0000_1007, 0);
        check_all("seq redir", 32'h0000_1004, 32'h0, 32'h0, 1'b0, 1'b0, 32'd2);
        check("seq imem", ImemInstruction, 32'd3);
        apply(0, 0, 0, 32'h0, 0);
        check_all("seq alias", 32'h0000_1008, 32'd3, 32'h0000_1008, 1'b1, 1'b0, 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- Fetch stage directly upstream of the instruction memory.
- Owns the program counter and drives the word address into the instruction memory. Samples the returned instruction word into the IF/ID pipeline register for decode.
- Handles stall from hazard detection, redirect (branch/jump) from later stages, and a sticky halt.
- The instruction memory is combinational and word-indexed on Address[11:2], so a fetch completes in the same cycle the PC is presented.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- PC_INCR, 4, byte increment per sequential fetch.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-low reset.
- ImemAddress  output  32  byte address to instruction memory; equals current PC.
- ImemInstruction  input  32  instruction word returned combinationally for ImemAddress.
- Stall  input  1  hold PC and IF/ID contents this cycle.
- Redirect  input  1  load RedirectTarget into PC and squash IF/ID.
- RedirectTarget  input  32  byte address of taken branch/jump target.
- Halt  input  1  enter HALTED; fetch stops until reset.
- IfId_Instruction  output  32  registered instruction for decode.
- IfId_PCPlus4  output  32  registered PC+4 of that instruction.
- IfId_Valid  output  1  IF/ID holds a real instruction.
- Halted  output  1  high while in HALTED state.

Behaviour:
- Reset:
  - Sampled only at a rising edge with Reset==0.
  - Loads PC=RESET_PC, IfId_Instruction=0 (NOP), IfId_PCPlus4=0, IfId_Valid=0, state=RUN, Halted=0.
  - Reset overrides every other input, including mid-stall, mid-redirect and HALTED.
- ImemAddress = PC, combinational, no extra latency.
- FSM states:
  - RUN -> HALTED when Halt==1 at an edge (and no reset).
  - HALTED -> RUN only via reset.
- RUN, priority per edge is Redirect > Stall > normal:
  - Redirect==1: PC <= {RedirectTarget[31:2],2'b00}; IF/ID cleared to NOP with Valid=0. Applies even if Stall==1 in the same cycle.
  - Stall==1 with Redirect==0: PC and all IfId_* outputs hold their values.
  - Normal: PC <= PC+PC_INCR; IfId_Instruction <= ImemInstruction; IfId_PCPlus4 <= PC+PC_INCR; IfId_Valid <= 1.
- Halt in the same cycle as Redirect or Stall: Halt wins. State goes to HALTED; PC holds; IF/ID cleared (NOP, Valid=0).
- HALTED: PC frozen; IF/ID holds NOP with Valid=0; Stall, Redirect and Halt are ignored; Halted=1.
- Latency:
  - The instruction at PC appears on IfId_* one cycle after PC is presented.
  - The first valid IF/ID entry is visible after the first non-stalled, non-redirected edge following reset release.
- Arithmetic:
  - PC+4 is 32-bit modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
  - Memory aliasing above bit 11 is the memory's concern; this stage does not truncate.
- Misaligned redirect targets are silently aligned by clearing bits [1:0].

Optional Feature:
- FETCH_COUNT_EN, when defined:
  - Adds output FetchCount[31:0].
  - Reset clears it to 0.
  - Increments by 1 on every edge that loads IfId_Valid=1; wraps at 2^32.
  - Holds on stall, redirect and halt.
- When undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package holds: RESET_PC default, PC_INCR, NOP_WORD=32'h0, the FSM state typedef (RUN, HALTED), and the IF/ID bundle typedef (instruction, pcplus4, valid).
- One natural sub-module: if_id_register, which holds the IF/ID bundle with hold (stall) and clear (flush) controls. PC register and FSM stay in the top module.

Test Plan:
- Reset then free run, memory model returning word i*3 at word address i: after reset release, edges 1..3 give IfId_Instruction=0,3,6, IfId_PCPlus4=4,8,12, Valid=1; ImemAddress=4,8,12.
- Stall for 2 cycles with PC=0x10: PC stays 0x10 and IfId_* holds both cycles; the next free edge gives Instruction=12, PCPlus4=0x14.
- Redirect with RedirectTarget=0x43 while Stall=1: next edge gives PC=0x40, Valid=0, Instruction=0; the following edge gives Instruction=48, PCPlus4=0x44.
- Halt at PC=0x20, with a simultaneous Redirect to 0x80: Halted=1, PC stays 0x20, Valid=0. Later Redirect/Stall/Halt pulses have no effect; Reset=0 for one edge gives PC=0, Halted=0.
- PC wrap: force RedirectTarget=32'hFFFF_FFFC, then one free edge: IfId_PCPlus4=0 and PC=0.
- Reset asserted mid-stall with Redirect high: next edge gives PC=RESET_PC, Valid=0, Halted=0. With FETCH_COUNT_EN defined, FetchCount=0, then it counts 1,2,3 over three free edges.
